fp_mul_round: RTL

Final rounding and packing stage of the FP multiplier datapath. Consumes the normalized 24-bit product mantissa, guard bit, sticky bit (from the sticky-bit stage), sign and extended biased exponent. Applies one of four IEEE-754 rounding modes, renormalizes on rounding carry-out, checks exponent range and packs a single-precision result with exception flags. It is a 2-stage pipeline with valid/ready flow control toward the FPU result bus.

---
 rtl/fp_mul_round.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fp_mul_round.sv
// fp_mul_round: final rounding and packing stage of the FP multiplier.
// Stage 1 applies the rounding increment, and stage 2 renormalizes, range-checks and packs
// an IEEE-754 single-precision result with exception flags.
module fp_mul_round (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [23:0] mant_in,
  input  logic        guard_in,
  input  logic        sticky_in,
  input  logic [1:0]  rnd_mode,
  input  logic        nan_in,
  input  logic        inf_in,
  input  logic        zero_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_inexact,
  output logic        flag_overflow,
  output logic        flag_underflow
);

  localparam logic [1:0] MODE_RNE = 2'b00;
  localparam logic [1:0] MODE_RTZ = 2'b01;
  localparam logic [1:0] MODE_RUP = 2'b10;

  logic        s1_valid;
  logic [24:0] s1_sum;
  logic        s1_sign;
  logic [9:0]  s1_exp;
  logic        s1_inexact;
  logic        s1_nan;
  logic        s1_inf;
  logic        s1_zero;
  logic [1:0]  s1_mode;

  logic        s2_adv;
  logic        inc;
  logic [24:0] sum_next;
  logic [10:0] adj_exp;
  logic [22:0] frac;
  logic        to_inf;
  logic [31:0] res_next;
  logic        inx_next;
  logic        ovf_next;
  logic        unf_next;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Rounding increment decision and rounded 25-bit sum (bit 24 is the carry-out)
  always_comb begin
    inc = 1'b0;
    case (rnd_mode)
      MODE_RNE: inc = guard_in && (sticky_in || mant_in[0]);
      MODE_RTZ: inc = 1'b0;
      MODE_RUP: inc = !sign_in && (guard_in || sticky_in);
      default:  inc = sign_in && (guard_in || sticky_in);
    endcase
    sum_next = {1'b0, mant_in} + {24'd0, inc};
  end

  // Stage 1 register: loads whenever the stage can accept new operands
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      s1_sign    <= 1'b0;
      s1_exp     <= '0;
      s1_inexact <= 1'b0;
      s1_nan     <= 1'b0;
      s1_inf     <= 1'b0;
      s1_zero    <= 1'b0;
      s1_mode    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum     <= sum_next;
        s1_sign    <= sign_in;
        s1_exp     <= exp_in;
        s1_inexact <= guard_in || sticky_in;
        s1_nan     <= nan_in;
        s1_inf     <= inf_in;
        s1_zero    <= zero_in;
        s1_mode    <= rnd_mode;
      end
    end
  end

  // Renormalize, range-check on the post-rounding exponent (11 bits so 511+1 cannot wrap), and pack
  always_comb begin
    adj_exp  = {s1_exp[9], s1_exp} + {10'd0, s1_sum[24]};
    frac     = s1_sum[24] ? s1_sum[23:1] : s1_sum[22:0];
    to_inf   = 1'b0;
    res_next = {s1_sign, adj_exp[7:0], frac};
    inx_next = s1_inexact;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (s1_nan) begin
      res_next = 32'h7FC00000;
      inx_next = 1'b0;
    end else if (s1_inf) begin
      res_next = {s1_sign, 8'hFF, 23'd0};
      inx_next = 1'b0;
    end else if (s1_zero) begin
      res_next = {s1_sign, 31'd0};
      inx_next = 1'b0;
    end else if ($signed(adj_exp) >= 11'sd255) begin
      case (s1_mode)
        MODE_RNE: to_inf = 1'b1;
        MODE_RTZ: to_inf = 1'b0;
        MODE_RUP: to_inf = !s1_sign;
        default:  to_inf = s1_sign;
      endcase
      res_next = {s1_sign, (to_inf ? 31'h7F800000 : 31'h7F7FFFFF)};
      inx_next = 1'b1;
      ovf_next = 1'b1;
    end else if ($signed(adj_exp) <= 11'sd0) begin
      res_next = {s1_sign, 31'd0};
      inx_next = 1'b1;
      unf_next = 1'b1;
    end
  end

  // Stage 2 / output register: holds its contents while the consumer stalls
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid      <= 1'b0;
      result         <= 32'h00000000;
      flag_inexact   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result         <= res_next;
        flag_inexact   <= inx_next;
        flag_overflow  <= ovf_next;
        flag_underflow <= unf_next;
      end
    end
  end

endmodule
